alu_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between two requesters: port 0 is execute stage, port 1 is address/aux unit.
- Arbitrates round-robin and latches the winner's operands and opcode into registers that drive the ALU inputs.
- Captures the ALU result and ZERO flag one cycle later and returns them with a one-cycle ACK pulse.
- Sits between the control unit / datapath requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Purpose: grants one of two requesters (0 = execute stage, 1 = address/aux
// unit), registers the winner's operands/opcode onto the ALU inputs, captures
// the ALU result and zero flag one cycle later and returns them with a
// one-cycle ACK pulse to the granted requester.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   REQn, OP1_n, OP2_n,
//   OPRN_n, ACKn (n = 0,1)   requester handshake, operands, opcode, ack pulse
//   ALU_OP1/ALU_OP2/ALU_OPRN registered operands/opcode driving the ALU
//   ALU_OUT, ALU_ZERO        combinational ALU result and zero flag
//   RESULT, RES_ZERO         registered result/zero, held until next capture
//   BUSY                     high while a transaction is in EXEC or DONE
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic [OPRN_WIDTH-1:0] OPRN_0,
    output logic                  ACK0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    input  logic [OPRN_WIDTH-1:0] OPRN_1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  RES_ZERO,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   op2_q, op2_d;
    logic [OPRN_WIDTH-1:0]   oprn_q, oprn_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        oprn_d   = oprn_q;
        result_d = result_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                // Requester 0 wins when alone, or on a tie when 1 was served last.
                if (REQ0 && (!REQ1 || last_q)) begin
                    gnt_d   = 1'b0;
                    last_d  = 1'b0;
                    op1_d   = OP1_0;
                    op2_d   = OP2_0;
                    oprn_d  = OPRN_0;
                    state_d = EXEC;
                end else if (REQ1) begin
                    gnt_d   = 1'b1;
                    last_d  = 1'b1;
                    op1_d   = OP1_1;
                    op2_d   = OP2_1;
                    oprn_d  = OPRN_1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = ALU_OUT;
                zero_d   = ALU_ZERO;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered from the next state so that they
        // line up with the DONE/EXEC cycles without a decode path to the pins.
        ack0_d = (state_d == DONE) && !gnt_d;
        ack1_d = (state_d == DONE) &&  gnt_d;
        busy_d = (state_d == EXEC) || (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            op1_q    <= '0;
            op2_q    <= '0;
            oprn_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            oprn_q   <= oprn_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    assign ALU_OP1  = op1_q;
    assign ALU_OP2  = op2_q;
    assign ALU_OPRN = oprn_q;
    assign RESULT   = result_q;
    assign RES_ZERO = zero_q;
    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and arbitration model
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [31:0] OP1_0 = '0, OP2_0 = '0, OP1_1 = '0, OP2_1 = '0;
    logic [5:0]  OPRN_0 = '0, OPRN_1 = '0;
    logic        ACK0, ACK1, RES_ZERO, BUSY, ALU_ZERO;
    logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT, RESULT;
    logic [5:0]  ALU_OPRN;

    int n_checks = 0;
    int n_fail   = 0;
    int last_gnt = 1;

    always #5 CLK = ~CLK;

    alu_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP1_0(OP1_0), .OP2_0(OP2_0), .OPRN_0(OPRN_0), .ACK0(ACK0),
        .REQ1(REQ1), .OP1_1(OP1_1), .OP2_1(OP2_1), .OPRN_1(OPRN_1), .ACK1(ACK1),
        .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
        .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
        .RESULT(RESULT), .RES_ZERO(RES_ZERO), .BUSY(BUSY)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a * b;
            6'd4:    return a >> b;
            6'd5:    return a << b;
            6'd6:    return a & b;
            6'd7:    return a | b;
            6'd8:    return ~(a | b);
            6'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    always_comb begin
        ALU_OUT  = alu_f(ALU_OP1, ALU_OP2, ALU_OPRN);
        ALU_ZERO = (ALU_OUT == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("ack_exclusive", {31'd0, ACK0 & ACK1}, 32'd0);
            chk("ack_only_busy", {31'd0, (ACK0 | ACK1) & ~BUSY}, 32'd0);
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1 RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
        last_gnt = 1;
    endtask

    // Wait for the next ACK, compare port and result against the model,
    // optionally drop the served request right after the DONE cycle.
    task automatic serve(input int exp_port, input logic [31:0] exp_res,
                         input bit drop, output int cyc);
        int got;
        got = -1;
        cyc = 0;
        for (int i = 0; i < 10 && got < 0; i++) begin
            @(negedge CLK);
            cyc++;
            if (ACK0) got = 0;
            else if (ACK1) got = 1;
        end
        if (got < 0) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            chk("ack_port", got, exp_port);
            chk("result", RESULT, exp_res);
            chk("res_zero", {31'd0, RES_ZERO}, {31'd0, exp_res == 32'd0});
        end
        last_gnt = exp_port;
        @(posedge CLK); #1;
        if (drop) begin
            if (got == 0) REQ0 = 1'b0;
            else if (got == 1) REQ1 = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] e0, e1;
        int both, first;

        // Reset state
        @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_ack0", {31'd0, ACK0}, 32'd0);
        chk("rst_ack1", {31'd0, ACK1}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_result", RESULT, 32'd0);
        chk("rst_res_zero", {31'd0, RES_ZERO}, 32'd0);
        chk("rst_alu_op1", ALU_OP1, 32'd0);
        chk("rst_alu_oprn", {26'd0, ALU_OPRN}, 32'd0);

        // Single add on port 0 with latency check
        @(posedge CLK); #1 REQ0 = 1'b1; OP1_0 = 32'd5; OP2_0 = 32'd7; OPRN_0 = 6'h1;
        @(negedge CLK);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        chk("grant_oprn", {26'd0, ALU_OPRN}, 32'd1);
        chk("exec_busy", {31'd0, BUSY}, 32'd1);
        chk("exec_no_ack", {30'd0, ACK1, ACK0}, 32'd0);
        @(negedge CLK);
        chk("add_ack0", {31'd0, ACK0}, 32'd1);
        chk("add_ack1", {31'd0, ACK1}, 32'd0);
        chk("add_result", RESULT, 32'd12);
        chk("add_zero", {31'd0, RES_ZERO}, 32'd0);
        @(posedge CLK); #1 REQ0 = 1'b0;
        last_gnt = 0;
        @(negedge CLK);
        chk("ack_pulse_end", {31'd0, ACK0}, 32'd0);
        chk("result_hold", RESULT, 32'd12);

        // Zero flag via port 1
        #1 REQ1 = 1'b1; OP1_1 = 32'd9; OP2_1 = 32'd9; OPRN_1 = 6'h2;
        serve(1, 32'd0, 1'b1, cyc);

        // Simultaneous first request after reset
        do_reset();
        REQ0 = 1'b1; OP1_0 = 32'h0000_F0F0; OP2_0 = 32'h0000_0FF0; OPRN_0 = 6'h6;
        REQ1 = 1'b1; OP1_1 = 32'd6; OP2_1 = 32'd7; OPRN_1 = 6'h3;
        serve(0, 32'h0000_00F0, 1'b1, cyc);
        chk("sim_latency0", cyc, 3);
        serve(1, 32'd42, 1'b1, cyc);
        chk("sim_spacing1", cyc, 3);

        // Fairness with both held high
        REQ0 = 1'b1; OP1_0 = 32'hFFFF_FFFF; OP2_0 = 32'd1; OPRN_0 = 6'h9;
        REQ1 = 1'b1; OP1_1 = 32'd100; OP2_1 = 32'd23; OPRN_1 = 6'h1;
        for (int k = 0; k < 4; k++) begin
            first = (last_gnt == 1) ? 0 : 1;
            serve(first, (first == 0) ? 32'd1 : 32'd123, k == 3, cyc);
            chk("fair_spacing", cyc, 3);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;

        // Operands sampled at grant only
        @(posedge CLK); #1 REQ0 = 1'b1; OP1_0 = 32'd3; OP2_0 = 32'd2; OPRN_0 = 6'h5;
        @(posedge CLK); #1 OP1_0 = 32'd100;
        serve(0, 32'd12, 1'b1, cyc);

        // Reset in the middle of a transaction
        REQ1 = 1'b1; OP1_1 = 32'd77; OP2_1 = 32'd1; OPRN_1 = 6'h1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midop_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0; REQ1 = 1'b0;
        last_gnt = 1;
        @(negedge CLK);
        chk("abort_result", RESULT, 32'd0);
        chk("abort_oprn", {26'd0, ALU_OPRN}, 32'd0);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("abort_no_ack", {30'd0, ACK1, ACK0}, 32'd0);
        end
        @(posedge CLK); #1 REQ1 = 1'b1; OP1_1 = 32'h0000_00F0; OP2_1 = 32'h0000_000F; OPRN_1 = 6'h7;
        serve(1, 32'h0000_00FF, 1'b1, cyc);
        chk("after_abort_latency", cyc, 3);

        // Randomized traffic against the arbitration and ALU model
        for (int it = 0; it < 40; it++) begin
            both = $urandom_range(1, 3);
            OP1_0 = $urandom; OP2_0 = $urandom_range(0, 40); OPRN_0 = 6'($urandom_range(0, 12));
            OP1_1 = $urandom; OP2_1 = $urandom_range(0, 40); OPRN_1 = 6'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) OP2_0 = OP1_0;
            e0 = alu_f(OP1_0, OP2_0, OPRN_0);
            e1 = alu_f(OP1_1, OP2_1, OPRN_1);
            REQ0 = both[0];
            REQ1 = both[1];
            if (both == 3) begin
                first = (last_gnt == 1) ? 0 : 1;
                serve(first, (first == 0) ? e0 : e1, 1'b1, cyc);
                chk("rnd_latency", cyc, 3);
                serve(1 - first, (first == 0) ? e1 : e0, 1'b1, cyc);
                chk("rnd_spacing", cyc, 3);
            end else begin
                serve(both - 1, (both == 1) ? e0 : e1, 1'b1, cyc);
                chk("rnd_latency", cyc, 3);
            end
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
